div: RTL and testbench

- Iterative 32-bit radix-2 divider consumed by the execute stage for DIV/DIVU.
- Operands are the reg1_o/reg2_o values produced by the decode stage.
- Execute asserts start_i and holds the pipeline stalled until ready_o returns the {remainder, quotient} pair, which is then written to HI/LO.
- Supports signed and unsigned division, divide-by-zero, and abort on pipeline flush.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div.sv | 200 ++++++++++++++++++++
 tb/tb_div.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider: state codes,
// result/request strobes and the execute-stage ALU operation codes.
package div_pkg;

    // Default operand width of the divider.
    localparam int DIV_WIDTH = 32;

    // Divider state machine encoding.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Result strobe levels.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Start request levels driven by execute.
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Instruction function codes and execute-stage ALU operations.
    localparam logic [5:0] EXE_DIV     = 6'b011010;
    localparam logic [5:0] EXE_DIVU    = 6'b011011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/div.sv
// Iterative radix-2 restoring divider. One quotient bit per cycle; signed
// operands are divided as magnitudes and the signs are restored at the end.
module div
    import div_pkg::*;
#(
    parameter int DW = DIV_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o
);

    localparam int            CW       = $clog2(DW) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DW);

    // Two's complement negation used for operand magnitudes and result signs.
    function automatic logic [DW-1:0] twos_neg(input logic [DW-1:0] v);
        return ~v + {{(DW-1){1'b0}}, 1'b1};
    endfunction

    div_state_e        state_q,    state_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic [2*DW:0]     dividend_q, dividend_d;
    logic [DW-1:0]     divisor_q,  divisor_d;
    logic              signed_q,   signed_d;
    logic              op1_neg_q,  op1_neg_d;
    logic              op2_neg_q,  op2_neg_d;
    logic [2*DW-1:0]   result_q,   result_d;
    logic              ready_q,    ready_d;

    logic              op1_neg_s;
    logic              op2_neg_s;
    logic [DW-1:0]     op1_mag_s;
    logic [DW-1:0]     op2_mag_s;
    logic [DW:0]       diff_s;
    logic [DW-1:0]     quot_s;
    logic [DW-1:0]     rem_s;

    // Operand magnitudes for the incoming request; only signed requests
    // with a set MSB are negated, unsigned operands pass through.
    always_comb begin
        op1_neg_s = signed_div_i & opdata1_i[DW-1];
        op2_neg_s = signed_div_i & opdata2_i[DW-1];
        if (op1_neg_s) begin
            op1_mag_s = twos_neg(opdata1_i);
        end else begin
            op1_mag_s = opdata1_i;
        end
        if (op2_neg_s) begin
            op2_mag_s = twos_neg(opdata2_i);
        end else begin
            op2_mag_s = opdata2_i;
        end
    end

    // Trial subtraction of the divisor from the upper partial remainder;
    // bit DW of the difference is the borrow (negative result).
    always_comb begin
        diff_s = dividend_q[2*DW:DW] - {1'b0, divisor_q};
    end

    // Final sign correction, decided from the latched operand signs so the
    // live inputs may change freely once the request is accepted.
    always_comb begin
        if (signed_q && (op1_neg_q ^ op2_neg_q)) begin
            quot_s = twos_neg(dividend_q[DW-1:0]);
        end else begin
            quot_s = dividend_q[DW-1:0];
        end
        if (signed_q && op1_neg_q) begin
            rem_s = twos_neg(dividend_q[2*DW:DW+1]);
        end else begin
            rem_s = dividend_q[2*DW:DW+1];
        end
    end

    // Next-state and datapath update for the divider state machine.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        op1_neg_d  = op1_neg_q;
        op2_neg_d  = op2_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if ((start_i == DIV_START) && !annul_i) begin
                    signed_d   = signed_div_i;
                    op1_neg_d  = op1_neg_s;
                    op2_neg_d  = op2_neg_s;
                    divisor_d  = op2_mag_s;
                    dividend_d = {{DW{1'b0}}, op1_mag_s, 1'b0};
                    cnt_d      = CNT_ZERO;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d = DIV_ON;
                    end
                end else begin
                    state_d = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
                // Zero quotient and remainder, reported one cycle later.
                dividend_d = '0;
                result_d   = '0;
                ready_d    = DIV_RESULT_READY;
                state_d    = DIV_END;
            end

            DIV_ON: begin
                if (annul_i) begin
                    // Flush: drop all partial work and go idle silently.
                    state_d    = DIV_FREE;
                    cnt_d      = CNT_ZERO;
                    dividend_d = '0;
                    ready_d    = DIV_RESULT_NOT_READY;
                    result_d   = '0;
                end else if (cnt_q != CNT_DONE) begin
                    if (diff_s[DW]) begin
                        dividend_d = {dividend_q[2*DW-1:0], 1'b0};
                    end else begin
                        dividend_d = {diff_s[DW-1:0], dividend_q[DW-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d  = DIV_END;
                    cnt_d    = CNT_ZERO;
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem_s, quot_s};
                end
            end

            DIV_END: begin
                // Hold the result until execute drops its request.
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                end
            end

            default: begin
                state_d    = DIV_FREE;
                cnt_d      = CNT_ZERO;
                dividend_d = '0;
                divisor_d  = '0;
                ready_d    = DIV_RESULT_NOT_READY;
                result_d   = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= CNT_ZERO;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            op1_neg_q  <= 1'b0;
            op2_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            op1_neg_q  <= op1_neg_d;
            op2_neg_q  <= op2_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the iterative divider: directed cases from the
// intended use plus randomized operands against an arithmetic reference.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int vectors;
    int miscompares;

    div #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division (truncating toward zero), result
    // packed as {remainder, quotient}; division by zero yields all zeros.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) begin
            return 64'd0;
        end
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
    endtask

    // Called right after issue(): waits for ready_o with a bound, checks
    // latency, result, hold while start stays high, and clear after drop.
    task automatic wait_check(input string tag, input logic [63:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, result_o, exp);
        @(posedge clk);
        #1;
        chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_res"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;

        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", 64'(ready_o), 64'd0);
        chk("reset_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rdy", 64'(ready_o), 64'd0);

        // Directed cases.
        issue(1'b0, 32'd100, 32'd7);
        wait_check("u100_7", {32'd2, 32'd14}, 34);
        issue(1'b1, 32'hFFFF_FFF9, 32'h2);
        wait_check("s_m7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_check("s_7_m2", {32'd1, 32'hFFFF_FFFD}, 34);
        issue(1'b0, 32'h1234, 32'd0);
        wait_check("divzero", 64'd0, 2);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_check("s_ovf", {32'd0, 32'h8000_0000}, 34);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_check("u_max_1", {32'd0, 32'hFFFF_FFFF}, 34);
        issue(1'b0, 32'd5, 32'd9);
        wait_check("u_small", {32'd5, 32'd0}, 34);

        // Start with annul held is ignored.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("annul_start_ignored", 64'(ready_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;

        // Abort at iteration 10, then immediately issue 9/3.
        issue(1'b0, 32'd1000, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        chk("annul_pre_rdy", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_post_rdy", 64'(ready_o), 64'd0);
        issue(1'b0, 32'd9, 32'd3);
        wait_check("after_annul", {32'd0, 32'd3}, 34);

        // Asynchronous reset mid-iteration, then a fresh request.
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_on_rdy", 64'(ready_o), 64'd0);
        chk("rst_on_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_check("post_rst", ref_div(1'b1, 32'hFFFF_FF9C, 32'd7), 34);

        // Asynchronous reset while a result is being held.
        issue(1'b0, 32'd100, 32'd7);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("end_rst_latency", 64'(lat), 64'd34);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_end_rdy", 64'(ready_o), 64'd0);
        chk("rst_end_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized operands against the reference.
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            issue(s, a, b);
            wait_check($sformatf("rand%0d", i), ref_div(s, a, b), (b == 32'd0) ? 2 : 34);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
